// File: rtl/divider.sv
// Sequential restoring divider: 16-bit unsigned dividend by 8-bit unsigned divisor.
// One setup cycle followed by 16 shift/subtract iterations; results publish on the last one.
module divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        ready,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        dbz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [4:0] LAST_ITER = 5'd16;

  state_e      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [15:0] dvd_q, dvd_d;
  logic [7:0]  dvs_q, dvs_d;
  logic [7:0]  prem_q, prem_d;
  logic        zero_q, zero_d;
  logic [15:0] quotient_q, quotient_d;
  logic [7:0]  remainder_q, remainder_d;
  logic        dbz_q, dbz_d;

  // Iteration datapath. The dividend register doubles as the quotient register:
  // each step shifts out the next dividend bit and shifts in the new quotient bit.
  logic [8:0]  trial;
  logic        take;
  logic [7:0]  prem_next;
  logic [15:0] shifted;

  always_comb begin
    trial     = {prem_q, dvd_q[15]};
    take      = (trial >= {1'b0, dvs_q});
    // When take is set the difference is below the divisor, so 8 bits hold it exactly.
    prem_next = take ? (trial[7:0] - dvs_q) : trial[7:0];
    shifted   = {dvd_q[14:0], take};
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    prem_d      = prem_q;
    zero_d      = zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE, DONE: begin
        if (load) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          count_d = 5'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        count_d = count_q + 5'd1;
        if (count_q == 5'd0) begin
          prem_d = 8'h00;
          zero_d = (dvs_q == 8'h00);
        end else begin
          prem_d = prem_next;
          dvd_d  = shifted;
          if (count_q == LAST_ITER) begin
            state_d     = DONE;
            quotient_d  = zero_q ? 16'hFFFF : shifted;
            remainder_d = zero_q ? 8'h00 : prem_next;
            dbz_d       = zero_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= 5'd0;
      dvd_q       <= 16'h0000;
      dvs_q       <= 8'h00;
      prem_q      <= 8'h00;
      zero_q      <= 1'b0;
      quotient_q  <= 16'h0000;
      remainder_q <= 8'h00;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      prem_q      <= prem_d;
      zero_q      <= zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign ready     = (state_q != BUSY);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed scenarios plus random operands
// compared against a plain arithmetic reference.
module tb_divider;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        dbz;

  int checks;
  int failures;

  // Last completed result as the reference expects it to be visible.
  int m_q;
  int m_r;
  int m_z;
  int pend_a;
  int pend_b;
  int lat;

  divider dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .dividend (dividend),
    .divisor  (divisor),
    .ready    (ready),
    .quotient (quotient),
    .remainder(remainder),
    .dbz      (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_held(input string tag);
    chk({tag, "_q_held"}, 32'(quotient), 32'(m_q));
    chk({tag, "_r_held"}, 32'(remainder), 32'(m_r));
    chk({tag, "_dbz_held"}, 32'(dbz), 32'(m_z));
  endtask

  task automatic start_op(input int a, input int b);
    dividend = 16'(a);
    divisor  = 8'(b);
    load     = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    chk("ready_low_after_accept", 32'(ready), 32'd0);
    pend_a = a;
    pend_b = b;
  endtask

  // Wait for completion; inject_at>0 pulses a load of 50/5 on that busy cycle.
  task automatic wait_done(input string tag, input int inject_at);
    int eq;
    int er;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      if (n == inject_at) begin
        dividend = 16'd50;
        divisor  = 8'd5;
        load     = 1'b1;
      end
      @(posedge clk); #1;
      load = 1'b0;
      if (ready) begin
        lat = n;
        break;
      end
      check_held({tag, "_busy"});
    end
    chk({tag, "_latency"}, 32'(lat), 32'd17);
    if (pend_b == 0) begin
      eq = 65535;
      er = 0;
    end else begin
      eq = pend_a / pend_b;
      er = pend_a % pend_b;
    end
    m_q = eq;
    m_r = er;
    m_z = (pend_b == 0) ? 1 : 0;
    chk({tag, "_q"}, 32'(quotient), 32'(m_q));
    chk({tag, "_r"}, 32'(remainder), 32'(m_r));
    chk({tag, "_dbz"}, 32'(dbz), 32'(m_z));
    if (pend_b != 0) begin
      chk({tag, "_identity"}, 32'(int'(quotient) * pend_b + int'(remainder)), 32'(pend_a));
      chk({tag, "_rem_lt_div"}, 32'(int'(remainder) < pend_b), 32'd1);
    end
    $display("op %0d / %0d -> q=%0d r=%0d dbz=%0b latency=%0d", pend_a, pend_b,
             quotient, remainder, dbz, lat);
  endtask

  task automatic idle_check(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      chk({tag, "_ready"}, 32'(ready), 32'd1);
      check_held(tag);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_q = 0; m_r = 0; m_z = 0;
    pend_a = 0; pend_b = 0; lat = 0;

    // Reset with a competing load: the load must be discarded.
    rst      = 1'b1;
    load     = 1'b1;
    dividend = 16'd1234;
    divisor  = 8'd5;
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    load = 1'b0;
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_q", 32'(quotient), 32'd0);
    chk("reset_r", 32'(remainder), 32'd0);
    chk("reset_dbz", 32'(dbz), 32'd0);
    idle_check("post_reset", 2);

    // Basic
    start_op(1000, 7);
    wait_done("basic", 0);
    chk("basic_q_const", 32'(quotient), 32'd142);
    chk("basic_r_const", 32'(remainder), 32'd6);
    idle_check("basic_hold", 3);

    // Extremes
    start_op(65535, 1);
    wait_done("max_by_1", 0);
    chk("max_by_1_q_const", 32'(quotient), 32'd65535);
    start_op(100, 200);
    wait_done("small_by_big", 0);
    chk("small_by_big_r_const", 32'(remainder), 32'd100);
    start_op(65535, 255);
    wait_done("max_by_255", 0);
    chk("max_by_255_q_const", 32'(quotient), 32'd257);

    // Divide by zero, then a normal operation clears the flag
    start_op(5, 0);
    wait_done("dbz", 0);
    chk("dbz_q_const", 32'(quotient), 32'hFFFF);
    chk("dbz_flag_const", 32'(dbz), 32'd1);
    start_op(9, 3);
    wait_done("after_dbz", 0);
    chk("after_dbz_flag_const", 32'(dbz), 32'd0);

    // Load while busy is ignored
    start_op(1000, 7);
    wait_done("busy_load", 5);
    chk("busy_load_q_const", 32'(quotient), 32'd142);
    chk("busy_load_r_const", 32'(remainder), 32'd6);
    idle_check("busy_load_hold", 4);

    // Reset mid-operation
    start_op(1000, 7);
    repeat (7) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_q = 0; m_r = 0; m_z = 0;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_q", 32'(quotient), 32'd0);
    chk("abort_r", 32'(remainder), 32'd0);
    chk("abort_dbz", 32'(dbz), 32'd0);
    idle_check("abort_hold", 20);
    start_op(81, 9);
    wait_done("after_abort", 0);
    chk("after_abort_q_const", 32'(quotient), 32'd9);

    // Back-to-back: load on the first cycle ready is high
    start_op(200, 3);
    wait_done("back_to_back", 0);
    chk("b2b_q_const", 32'(quotient), 32'd66);
    chk("b2b_r_const", 32'(remainder), 32'd2);

    // Random operands, occasional zero divisor and idle gaps
    for (int i = 0; i < 1000; i++) begin
      int a;
      int b;
      int gap;
      a   = int'($urandom_range(0, 65535));
      b   = (i % 50 == 0) ? 0 : int'($urandom_range(0, 255));
      gap = int'($urandom_range(0, 2));
      if (gap > 0) idle_check("rand_gap", gap);
      start_op(a, b);
      wait_done("rand", 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
